// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the 16-bit-instruction multicycle MIPS core.
// Holds the opcode, R-type funct, FSM state and ALU-control enumerations
// plus a helper that maps an R-type funct field onto an ALU operation.
package mips_pkg;

    typedef enum logic [2:0] {
        OP_RTYPE = 3'b000,
        OP_LW    = 3'b001,
        OP_SW    = 3'b010,
        OP_BEQ   = 3'b011,
        OP_ADDI  = 3'b100,
        OP_J     = 3'b101,
        OP_BNE   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_e;

    typedef enum logic [3:0] {
        FN_ADD = 4'h0,
        FN_SUB = 4'h1,
        FN_AND = 4'h2,
        FN_OR  = 4'h3,
        FN_SLT = 4'h4
    } funct_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_NONE = 3'd5
    } aluctl_e;

    // Unknown funct codes map to ALU_NONE, which the datapath treats as
    // "retire without writing a register".
    function automatic aluctl_e decodeFunct(input logic [3:0] funct);
        aluctl_e ctl;
        case (funct)
            FN_ADD:  ctl = ALU_ADD;
            FN_SUB:  ctl = ALU_SUB;
            FN_AND:  ctl = ALU_AND;
            FN_OR:   ctl = ALU_OR;
            FN_SLT:  ctl = ALU_SLT;
            default: ctl = ALU_NONE;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// mc_controller: sequencing FSM of the multicycle core.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   op_i              - opcode of the latched instruction
//   imem_ready_i      - instruction memory handshake
//   dmem_ready_i      - data memory handshake
//   state_o           - current FSM state, steers the datapath
//   imem_req_o        - registered instruction fetch request
//   dmem_req_o        - registered data access request
//   dmem_we_o         - registered data write enable (sw)
//   halted_o          - registered "core stopped" flag
//   fetchDone_o       - instruction accepted this cycle
//   memDone_o         - data access completes this cycle
module mc_controller
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  opcode_e op_i,
    input  logic    imem_ready_i,
    input  logic    dmem_ready_i,
    output state_e  state_o,
    output logic    imem_req_o,
    output logic    dmem_req_o,
    output logic    dmem_we_o,
    output logic    halted_o,
    output logic    fetchDone_o,
    output logic    memDone_o
);

    state_e state_q;
    logic   imemReq_q;
    logic   dmemReq_q;
    logic   dmemWe_q;
    logic   halted_q;

    // A ready is only honoured while our own request is up, so a ready
    // arriving after a reset dropped the request is ignored.
    assign fetchDone_o = (state_q == S_FETCH) && imemReq_q && imem_ready_i;
    assign memDone_o   = (state_q == S_MEM) && dmemReq_q && dmem_ready_i;

    assign state_o    = state_q;
    assign imem_req_o = imemReq_q;
    assign dmem_req_o = dmemReq_q;
    assign dmem_we_o  = dmemWe_q;
    assign halted_o   = halted_q;

    // Requests are raised on the edge that enters FETCH/MEM and dropped on
    // the edge that completes the handshake. Right after reset the core sits
    // in FETCH with no request, so the first cycle out of reset raises it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            imemReq_q <= 1'b0;
            dmemReq_q <= 1'b0;
            dmemWe_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!imemReq_q) begin
                        imemReq_q <= 1'b1;
                    end else if (fetchDone_o) begin
                        imemReq_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op_i)
                        OP_J: begin
                            state_q   <= S_FETCH;
                            imemReq_q <= 1'b1;
                        end
                        OP_HALT: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                        default: state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (op_i)
                        OP_LW, OP_SW: begin
                            state_q   <= S_MEM;
                            dmemReq_q <= 1'b1;
                            dmemWe_q  <= (op_i == OP_SW);
                        end
                        OP_RTYPE, OP_ADDI: state_q <= S_WB;
                        default: begin
                            state_q   <= S_FETCH;
                            imemReq_q <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (memDone_o) begin
                        dmemReq_q <= 1'b0;
                        dmemWe_q  <= 1'b0;
                        if (op_i == OP_SW) begin
                            state_q   <= S_FETCH;
                            imemReq_q <= 1'b1;
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    state_q   <= S_FETCH;
                    imemReq_q <= 1'b1;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q   <= S_FETCH;
                    imemReq_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS-like core with 16-bit instructions.
// Datapath, 8-entry register file and ALU live here; sequencing is in
// mc_controller.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   imem_req/addr/rdata/ready     - instruction fetch handshake
//   dmem_req/we/addr/wdata/rdata/ready - data memory handshake
//   pc                            - current program counter
//   halted                        - core has executed halt
module mips_multicycle
    import mips_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    state_e            state;
    logic              fetchDone;
    logic              memDone;

    logic [15:0]       instr_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] aluOut_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] dmemAddr_q;
    logic [DATA_W-1:0] dmemWdata_q;
    logic [DATA_W-1:0] regFile_q [8];

    opcode_e           op;
    logic [2:0]        rs;
    logic [2:0]        rt;
    logic [2:0]        rd;
    logic [3:0]        funct;
    logic [DATA_W-1:0] immData;
    logic [PC_W-1:0]   immPc;
    logic [PC_W-1:0]   jumpTarget;
    logic [PC_W-1:0]   pcSeq;
    logic [PC_W-1:0]   pcBranch;
    logic [DATA_W-1:0] rfA;
    logic [DATA_W-1:0] rfB;

    aluctl_e           aluCtl;
    logic [DATA_W-1:0] aluResult;
    logic              wbEn;
    logic [2:0]        wbAddr;
    logic [DATA_W-1:0] wbData;

    mc_controller uController (
        .clk          (clk),
        .reset        (reset),
        .op_i         (op),
        .imem_ready_i (imem_ready),
        .dmem_ready_i (dmem_ready),
        .state_o      (state),
        .imem_req_o   (imem_req),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .halted_o     (halted),
        .fetchDone_o  (fetchDone),
        .memDone_o    (memDone)
    );

    assign op         = opcode_e'(instr_q[15:13]);
    assign rs         = instr_q[12:10];
    assign rt         = instr_q[9:7];
    assign rd         = instr_q[6:4];
    assign funct      = instr_q[3:0];
    assign immData    = {{(DATA_W-7){instr_q[6]}}, instr_q[6:0]};
    assign immPc      = {{(PC_W-7){instr_q[6]}}, instr_q[6:0]};
    assign jumpTarget = PC_W'(instr_q[12:0]);
    assign pcSeq      = pc_q + PC_W'(1);
    assign pcBranch   = pcSeq + immPc;

    // r0 is hard-wired to zero on the read side as well as the write side.
    assign rfA = (rs == 3'd0) ? '0 : regFile_q[rs];
    assign rfB = (rt == 3'd0) ? '0 : regFile_q[rt];

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign dmem_addr  = dmemAddr_q;
    assign dmem_wdata = dmemWdata_q;

    // R-type ALU; slt compares the operands as two's-complement values.
    always_comb begin
        aluCtl    = decodeFunct(funct);
        aluResult = '0;
        case (aluCtl)
            ALU_ADD: aluResult = a_q + b_q;
            ALU_SUB: aluResult = a_q - b_q;
            ALU_AND: aluResult = a_q & b_q;
            ALU_OR:  aluResult = a_q | b_q;
            ALU_SLT: aluResult = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: aluResult = '0;
        endcase
    end

    // The PC only moves at the point an instruction retires: jumps in
    // DECODE, branches in EXEC, stores when memory accepts, others in WB.
    always_comb begin
        pc_d = pc_q;
        case (state)
            S_DECODE: if (op == OP_J) pc_d = jumpTarget;
            S_EXEC: begin
                if (op == OP_BEQ) pc_d = (a_q == b_q) ? pcBranch : pcSeq;
                else if (op == OP_BNE) pc_d = (a_q != b_q) ? pcBranch : pcSeq;
            end
            S_MEM:   if (memDone && (op == OP_SW)) pc_d = pcSeq;
            S_WB:    pc_d = pcSeq;
            default: pc_d = pc_q;
        endcase
    end

    // Write-back selection: rd for R-type, rt for addi/lw; unknown functs
    // and writes aimed at r0 are dropped.
    always_comb begin
        wbEn   = 1'b0;
        wbAddr = rt;
        wbData = aluOut_q;
        if (state == S_WB) begin
            case (op)
                OP_RTYPE: begin
                    wbEn   = (aluCtl != ALU_NONE);
                    wbAddr = rd;
                end
                OP_ADDI: wbEn = 1'b1;
                OP_LW: begin
                    wbEn   = 1'b1;
                    wbData = mdr_q;
                end
                default: wbEn = 1'b0;
            endcase
            if (wbAddr == 3'd0) wbEn = 1'b0;
        end
    end

    // Datapath registers. The memory address and store data are captured in
    // EXEC so they are stable for the whole MEM handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= '0;
            instr_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            aluOut_q    <= '0;
            mdr_q       <= '0;
            dmemAddr_q  <= '0;
            dmemWdata_q <= '0;
            for (int i = 0; i < 8; i++) regFile_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (fetchDone) instr_q <= imem_rdata;
            if (state == S_DECODE) begin
                a_q <= rfA;
                b_q <= rfB;
            end
            if (state == S_EXEC) begin
                aluOut_q <= (op == OP_ADDI) ? (a_q + immData) : aluResult;
                if ((op == OP_LW) || (op == OP_SW)) begin
                    dmemAddr_q  <= a_q + immData;
                    dmemWdata_q <= b_q;
                end
            end
            if (memDone && (op == OP_LW)) mdr_q <= dmem_rdata;
            if (wbEn) regFile_q[wbAddr] <= wbData;
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed self-checking bench. An 8-bit core runs the
// sequencing, timing, branch, jump/halt and reset scenarios against a bench
// memory model with configurable ready stalls; a 16-bit core runs the
// signed-compare / r0 / ALU program and stores its results for inspection.
module tb_mips_multicycle;

    logic        clk;
    logic        reset;

    logic        imemReq8, imemReady8, dmemReq8, dmemWe8, dmemReady8, halted8;
    logic [15:0] imemAddr8, imemRdata8, pc8;
    logic [7:0]  dmemAddr8, dmemWdata8, dmemRdata8;

    logic        imemReq16, imemReady16, dmemReq16, dmemWe16, dmemReady16, halted16;
    logic [15:0] imemAddr16, imemRdata16, pc16;
    logic [15:0] dmemAddr16, dmemWdata16, dmemRdata16;

    logic [15:0] prog8  [0:1023];
    logic [7:0]  dmem8  [0:255];
    logic [15:0] prog16 [0:63];
    logic [15:0] dmem16 [0:15];
    logic [7:0]  wrAddr8 [0:7];
    logic [7:0]  wrData8 [0:7];

    int total, bad;
    int imemStallCfg, dmemStallCfg, iWait, dWait;
    int wrCount8, rdCount8, wrCount16, overlapCount;
    logic imemForceReady;
    int n, cnt;

    mips_multicycle dut8 (
        .clk(clk), .reset(reset),
        .imem_req(imemReq8), .imem_addr(imemAddr8), .imem_rdata(imemRdata8), .imem_ready(imemReady8),
        .dmem_req(dmemReq8), .dmem_we(dmemWe8), .dmem_addr(dmemAddr8), .dmem_wdata(dmemWdata8),
        .dmem_rdata(dmemRdata8), .dmem_ready(dmemReady8), .pc(pc8), .halted(halted8)
    );

    mips_multicycle #(.DATA_W(16), .PC_W(16)) dut16 (
        .clk(clk), .reset(reset),
        .imem_req(imemReq16), .imem_addr(imemAddr16), .imem_rdata(imemRdata16), .imem_ready(imemReady16),
        .dmem_req(dmemReq16), .dmem_we(dmemWe16), .dmem_addr(dmemAddr16), .dmem_wdata(dmemWdata16),
        .dmem_rdata(dmemRdata16), .dmem_ready(dmemReady16), .pc(pc16), .halted(halted16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] encR(input logic [2:0] rs, input logic [2:0] rt,
                                         input logic [2:0] rd, input logic [3:0] fn);
        return {3'b000, rs, rt, rd, fn};
    endfunction

    function automatic logic [15:0] encI(input logic [2:0] op, input logic [2:0] rs,
                                         input logic [2:0] rt, input logic [6:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [15:0] encJ(input logic [12:0] target);
        return {3'b101, target};
    endfunction

    // Memory responses are driven on the falling edge from the request
    // outputs, then the rising edge is taken and outputs settle for 1ns.
    task automatic applyStimulus();
        @(negedge clk);
        if (imemReq8 && dmemReq8) overlapCount++;
        if (imemReq16 && dmemReq16) overlapCount++;
        if (imemReq8) begin
            if (iWait < imemStallCfg) begin
                imemReady8 = 1'b0;
                iWait++;
            end else begin
                imemReady8 = 1'b1;
                iWait = 0;
            end
        end else begin
            imemReady8 = imemForceReady;
            iWait = 0;
        end
        imemRdata8 = prog8[imemAddr8[9:0]];
        dmemRdata8 = dmem8[dmemAddr8];
        if (dmemReq8) begin
            if (dWait < dmemStallCfg) begin
                dmemReady8 = 1'b0;
                dWait++;
            end else begin
                dmemReady8 = 1'b1;
                dWait = 0;
                if (dmemWe8) begin
                    dmem8[dmemAddr8] = dmemWdata8;
                    if (wrCount8 < 8) begin
                        wrAddr8[wrCount8] = dmemAddr8;
                        wrData8[wrCount8] = dmemWdata8;
                    end
                    wrCount8++;
                end else begin
                    rdCount8++;
                end
            end
        end else begin
            dmemReady8 = 1'b0;
            dWait = 0;
        end
        imemReady16 = imemReq16;
        imemRdata16 = prog16[imemAddr16[5:0]];
        dmemReady16 = dmemReq16;
        dmemRdata16 = dmem16[dmemAddr16[3:0]];
        if (dmemReq16 && dmemWe16) begin
            dmem16[dmemAddr16[3:0]] = dmemWdata16;
            wrCount16++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        repeat (3) applyStimulus();
        wrCount8 = 0;
        rdCount8 = 0;
        iWait    = 0;
        dWait    = 0;
    endtask

    task automatic runUntilPc(input logic [15:0] target, input int limit, output int steps);
        steps = 0;
        while ((pc8 !== target) && (steps < limit)) begin
            applyStimulus();
            steps++;
        end
    endtask

    task automatic runUntilHalt(input int limit);
        int s;
        s = 0;
        while ((halted8 !== 1'b1) && (s < limit)) begin
            applyStimulus();
            s++;
        end
    endtask

    task automatic clearProg8();
        for (int i = 0; i < 1024; i++) prog8[i] = 16'hE000;
    endtask

    initial begin
        total = 0; bad = 0;
        imemStallCfg = 0; dmemStallCfg = 0; iWait = 0; dWait = 0;
        wrCount8 = 0; rdCount8 = 0; wrCount16 = 0; overlapCount = 0;
        imemForceReady = 1'b0;
        imemReady8 = 1'b0; dmemReady8 = 1'b0; imemRdata8 = '0; dmemRdata8 = '0;
        imemReady16 = 1'b0; dmemReady16 = 1'b0; imemRdata16 = '0; dmemRdata16 = '0;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) dmem8[i] = 8'h00;
        for (int i = 0; i < 16; i++) dmem16[i] = 16'hDEAD;
        for (int i = 0; i < 8; i++) begin
            wrAddr8[i] = '0;
            wrData8[i] = '0;
        end
        for (int i = 0; i < 64; i++) prog16[i] = 16'hE000;
        prog16[0]  = encI(3'b100, 3'd0, 3'd1, 7'h7F);
        prog16[1]  = encR(3'd1, 3'd0, 3'd2, 4'h4);
        prog16[2]  = encR(3'd1, 3'd1, 3'd0, 4'h0);
        prog16[3]  = encI(3'b010, 3'd0, 3'd1, 7'd0);
        prog16[4]  = encI(3'b010, 3'd0, 3'd2, 7'd1);
        prog16[5]  = encI(3'b010, 3'd0, 3'd0, 7'd2);
        prog16[6]  = encR(3'd1, 3'd1, 3'd2, 4'hF);
        prog16[7]  = encI(3'b010, 3'd0, 3'd2, 7'd3);
        prog16[8]  = encR(3'd2, 3'd1, 3'd4, 4'h1);
        prog16[9]  = encR(3'd1, 3'd4, 3'd5, 4'h2);
        prog16[10] = encR(3'd4, 3'd2, 3'd6, 4'h3);
        prog16[11] = encI(3'b010, 3'd0, 3'd4, 7'd4);
        prog16[12] = encI(3'b010, 3'd0, 3'd5, 7'd5);
        prog16[13] = encI(3'b010, 3'd0, 3'd6, 7'd6);

        // addi/addi/add sequence, then store r3 and halt
        clearProg8();
        prog8[0] = encI(3'b100, 3'd0, 3'd1, 7'd5);
        prog8[1] = encI(3'b100, 3'd0, 3'd2, 7'h7D);
        prog8[2] = encR(3'd1, 3'd2, 3'd3, 4'h0);
        prog8[3] = encI(3'b010, 3'd0, 3'd3, 7'd0);
        resetDut();
        checkOutput("rst_pc", pc8, 0);
        checkOutput("rst_imem_req", imemReq8, 0);
        checkOutput("rst_dmem_req", dmemReq8, 0);
        checkOutput("rst_dmem_we", dmemWe8, 0);
        checkOutput("rst_halted", halted8, 0);
        checkOutput("rst_dmem_addr", dmemAddr8, 0);
        checkOutput("rst_dmem_wdata", dmemWdata8, 0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("first_req", imemReq8, 1);
        checkOutput("first_addr", imemAddr8, 0);
        runUntilPc(16'd3, 50, n);
        checkOutput("seq3_cycles", n, 12);
        runUntilHalt(100);
        checkOutput("seq3_halted", halted8, 1);
        checkOutput("seq3_pc", pc8, 4);
        checkOutput("seq3_wrcount", wrCount8, 1);
        checkOutput("seq3_r3_addr", wrAddr8[0], 0);
        checkOutput("seq3_r3_data", wrData8[0], 2);

        // sw/lw with three ready-low cycles on each data access
        clearProg8();
        prog8[0] = encI(3'b100, 3'd0, 3'd1, 7'd5);
        prog8[1] = encI(3'b010, 3'd0, 3'd1, 7'd4);
        prog8[2] = encI(3'b001, 3'd0, 3'd4, 7'd4);
        prog8[3] = encI(3'b010, 3'd0, 3'd4, 7'd8);
        dmemStallCfg = 3;
        resetDut();
        reset = 1'b0;
        applyStimulus();
        runUntilPc(16'd1, 50, n);
        checkOutput("addi_cycles", n, 4);
        runUntilPc(16'd2, 50, n);
        checkOutput("sw_stall_cycles", n, 7);
        runUntilPc(16'd3, 50, n);
        checkOutput("lw_stall_cycles", n, 8);
        runUntilHalt(100);
        checkOutput("mem_wrcount", wrCount8, 2);
        checkOutput("sw_addr", wrAddr8[0], 4);
        checkOutput("sw_data", wrData8[0], 5);
        checkOutput("lw_r4_addr", wrAddr8[1], 8);
        checkOutput("lw_r4_data", wrData8[1], 5);
        checkOutput("mem_rdcount", rdCount8, 1);
        dmemStallCfg = 0;

        // beq r0,r0,-1 at pc 7 loops on itself every 3 cycles
        clearProg8();
        prog8[0] = encJ(13'd7);
        prog8[7] = encI(3'b011, 3'd0, 3'd0, 7'h7F);
        resetDut();
        reset = 1'b0;
        applyStimulus();
        runUntilPc(16'd7, 20, n);
        checkOutput("j7_cycles", n, 2);
        applyStimulus();
        checkOutput("beq_decode_noreq", imemReq8, 0);
        applyStimulus();
        applyStimulus();
        checkOutput("beq_refetch_req", imemReq8, 1);
        checkOutput("beq_pc", pc8, 7);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus();
            if (imemReq8) cnt++;
        end
        checkOutput("beq_loop_fetches", cnt, 10);
        checkOutput("beq_loop_pc", pc8, 7);

        // bne r0,r0,-1 at pc 7 falls through to 8
        prog8[7] = encI(3'b110, 3'd0, 3'd0, 7'h7F);
        resetDut();
        reset = 1'b0;
        applyStimulus();
        runUntilPc(16'd7, 20, n);
        runUntilPc(16'd8, 20, n);
        checkOutput("bne_cycles", n, 3);

        // j 0x0100 then halt: core stops and stays quiet
        clearProg8();
        prog8[0] = encJ(13'h100);
        resetDut();
        reset = 1'b0;
        applyStimulus();
        runUntilPc(16'h0100, 20, n);
        checkOutput("j100_cycles", n, 2);
        checkOutput("j100_fetch_req", imemReq8, 1);
        applyStimulus();
        applyStimulus();
        checkOutput("halt_flag", halted8, 1);
        checkOutput("halt_pc", pc8, 16'h0100);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (imemReq8 || dmemReq8) cnt++;
        end
        checkOutput("halt_no_req", cnt, 0);
        checkOutput("halt_still", halted8, 1);

        // reset during a stalled fetch, then a stray ready after reset
        resetDut();
        reset = 1'b0;
        applyStimulus();
        imemStallCfg = 1000;
        applyStimulus();
        applyStimulus();
        checkOutput("stall_req", imemReq8, 1);
        checkOutput("stall_pc", pc8, 0);
        reset = 1'b1;
        applyStimulus();
        checkOutput("rst_drop_req", imemReq8, 0);
        checkOutput("rst_drop_pc", pc8, 0);
        imemStallCfg = 0;
        imemForceReady = 1'b1;
        reset = 1'b0;
        applyStimulus();
        imemForceReady = 1'b0;
        checkOutput("late_ready_ignored", imemReq8, 1);
        checkOutput("refetch_addr", imemAddr8, 0);
        runUntilPc(16'h0100, 20, n);
        checkOutput("refetch_j_cycles", n, 2);

        // 16-bit core: signed slt, r0 discard, invalid funct, sub/and/or
        for (int i = 0; i < 16; i++) dmem16[i] = 16'hDEAD;
        resetDut();
        wrCount16 = 0;
        reset = 1'b0;
        cnt = 0;
        while ((halted16 !== 1'b1) && (cnt < 300)) begin
            applyStimulus();
            cnt++;
        end
        checkOutput("w16_halted", halted16, 1);
        checkOutput("w16_r1", dmem16[0], 16'hFFFF);
        checkOutput("w16_slt_r2", dmem16[1], 16'h0001);
        checkOutput("w16_r0", dmem16[2], 16'h0000);
        checkOutput("w16_badfunct_r2", dmem16[3], 16'h0001);
        checkOutput("w16_sub", dmem16[4], 16'h0002);
        checkOutput("w16_and", dmem16[5], 16'h0002);
        checkOutput("w16_or", dmem16[6], 16'h0003);
        checkOutput("w16_wrcount", wrCount16, 7);

        checkOutput("req_overlap", overlapCount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
